// File: rtl/uart_pkg.sv
// Shared UART definitions: scheduler state encoding and frame timing helper,
// reused by uart_tx_sched, uart_tx and uart_rx.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TRIG = 2'd1,
        WAIT = 2'd2
    } sched_state_t;

    // One frame is start + 8 data + stop bits, plus idle guard cycles; division truncates.
    function automatic int frame_cycles(input int clk_freq, input int baud, input int guard);
        return (clk_freq / baud) * 10 + guard;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first active request after
// index `last`, wrapping modulo N.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 any
);

    localparam int IW = $clog2(N);

    function automatic logic [IW-1:0] rr_index(input logic [IW-1:0] base, input int offset);
        return IW'((int'(base) + offset) % N);
    endfunction

    always_comb begin
        gnt_id = last;
        any    = 1'b0;
        // Scan farthest-to-nearest so the requester closest after `last` overwrites the rest.
        for (int k = N; k >= 1; k--) begin
            if (req[rr_index(last, k)]) begin
                gnt_id = rr_index(last, k);
                any    = 1'b1;
            end
        end
        gnt = '0;
        if (any) begin
            gnt[gnt_id] = 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx among N_REQ byte producers; since
// uart_tx has no busy output, triggers are spaced by a full frame time.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600,
    parameter int GUARD    = 16
) (
    input  logic                     sclk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [8*N_REQ-1:0]       req_data,
    output logic [N_REQ-1:0]         req_ready,
    output logic [7:0]               tx_data,
    output logic                     tx_trig,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] grant_id
);

    localparam int IW           = $clog2(N_REQ);
    localparam int FRAME_CYCLES = frame_cycles(CLK_FREQ, BAUD, GUARD);
    localparam int CW           = $clog2(FRAME_CYCLES + 1);

    sched_state_t     r_state;
    logic [CW-1:0]    r_cnt;
    logic [N_REQ-1:0] w_gnt;
    logic [IW-1:0]    w_gnt_id;
    logic             w_any;
    logic [7:0]       w_bytes [N_REQ];

    rr_arbiter #(
        .N(N_REQ)
    ) u_arb (
        .req    (req_valid),
        .last   (grant_id),
        .gnt    (w_gnt),
        .gnt_id (w_gnt_id),
        .any    (w_any)
    );

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_bytes
        assign w_bytes[gi] = req_data[8*gi +: 8];
    end

    // Grants are offered only while idle, so at most one handshake per frame.
    assign req_ready = (r_state == IDLE) ? w_gnt : '0;

    always_ff @(posedge sclk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            tx_trig  <= 1'b0;
            tx_data  <= 8'h00;
            busy     <= 1'b0;
            grant_id <= IW'(N_REQ - 1);
        end else begin
            // NOTE: non-blocking only, so every register updates from the same pre-edge values.
            tx_trig <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        tx_data  <= w_bytes[w_gnt_id];
                        grant_id <= w_gnt_id;
                        busy     <= 1'b1;
                        tx_trig  <= 1'b1;
                        r_state  <= TRIG;
                    end
                end
                TRIG: begin
                    r_cnt   <= CW'(FRAME_CYCLES - 1);
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: directed scenarios plus a randomized
// phase, all compared every cycle against a frame-timeline reference model.
module tb_uart_tx_sched;

    localparam int N        = 4;
    localparam int CLK_FREQ = 50_000_000;
    localparam int BAUD     = 5_000_000;
    localparam int GUARD    = 2;
    localparam int FRAME    = (CLK_FREQ / BAUD) * 10 + GUARD;  // 102

    logic           sclk      = 1'b0;
    logic           reset     = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data  = '0;
    logic [N-1:0]   req_ready;
    logic [7:0]     tx_data;
    logic           tx_trig;
    logic           busy;
    logic [1:0]     grant_id;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model: the whole schedule follows from the cycle of the last trigger.
    int           m_trig = -1000;
    int           m_last = N - 1;
    logic [7:0]   m_data = 8'h00;
    logic [N-1:0] m_hs   = '0;

    // Observation log for the directed literal checks.
    int           trig_cyc_q[$];
    logic [7:0]   trig_data_q[$];
    int           trig_gid_q[$];
    int           rdy_cyc_q[$];
    logic [N-1:0] rdy_val_q[$];
    int           busy_cnt = 0;

    uart_tx_sched #(
        .N_REQ    (N),
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .GUARD    (GUARD)
    ) dut (
        .sclk      (sclk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_trig   (tx_trig),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always #5 sclk = ~sclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Every negedge: compare DUT against the model, log events, then advance the model.
    initial begin : compare
        logic [N-1:0] exp_ready;
        int           win;
        forever begin
            @(negedge sclk);
            cyc++;
            win = -1;
            if (cyc > m_trig + FRAME) begin
                for (int k = 1; k <= N; k++) begin
                    if (win < 0 && req_valid[2'((m_last + k) % N)]) begin
                        win = (m_last + k) % N;
                    end
                end
            end
            exp_ready = '0;
            if (win >= 0) exp_ready[2'(win)] = 1'b1;

            check("req_ready", 32'(req_ready), 32'(exp_ready));
            check("tx_trig", 32'(tx_trig), 32'(cyc == m_trig));
            check("busy", 32'(busy), 32'(cyc >= m_trig && cyc <= m_trig + FRAME));
            check("tx_data", 32'(tx_data), 32'(m_data));
            check("grant_id", 32'(grant_id), 32'(m_last));

            if (tx_trig === 1'b1) begin
                trig_cyc_q.push_back(cyc);
                trig_data_q.push_back(tx_data);
                trig_gid_q.push_back(int'(grant_id));
            end
            if (req_ready !== '0) begin
                rdy_cyc_q.push_back(cyc);
                rdy_val_q.push_back(req_ready);
            end
            if (busy === 1'b1) busy_cnt++;

            m_hs = '0;
            if (reset) begin
                m_trig = -1000;
                m_last = N - 1;
                m_data = 8'h00;
            end else if (win >= 0) begin
                m_hs   = exp_ready;
                m_last = win;
                m_data = 8'(req_data >> (8 * win));
                m_trig = cyc + 1;
            end
        end
    end

    // Advance one clock; producers drop a request once its handshake has happened.
    task automatic tick();
        @(posedge sclk);
        #1;
        req_valid = req_valid & ~m_hs;
    endtask

    task automatic clear_log();
        trig_cyc_q.delete();
        trig_data_q.delete();
        trig_gid_q.delete();
        rdy_cyc_q.delete();
        rdy_val_q.delete();
        busy_cnt = 0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    task automatic wait_trigs(input int n, input int budget);
        for (int i = 0; i < budget && trig_cyc_q.size() < n; i++) tick();
    endtask

    task automatic wait_quiet();
        for (int i = 0; i < 300 && busy !== 1'b0; i++) tick();
        repeat (2) tick();
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int t0;
        int first3;
        int n_rdy1;

        // Reset values.
        repeat (10) tick();
        check("rst_tx_data", 32'(tx_data), 32'h00);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_trig", 32'(tx_trig), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd3);
        reset = 1'b0;

        // Single request.
        clear_log();
        req_data[7:0] = 8'hC3;
        req_valid     = 4'b0001;
        repeat (120) tick();
        check("t1_ready_pulses", rdy_cyc_q.size(), 1);
        check("t1_trig_count", trig_cyc_q.size(), 1);
        if (rdy_cyc_q.size() == 1 && trig_cyc_q.size() == 1) begin
            check("t1_ready_val", 32'(rdy_val_q[0]), 32'b0001);
            check("t1_latency", trig_cyc_q[0] - rdy_cyc_q[0], 1);
            check("t1_data", 32'(trig_data_q[0]), 32'hC3);
        end
        check("t1_busy_cycles", busy_cnt, 103);

        // All four requesters contend.
        do_reset(3);
        clear_log();
        req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        req_valid = 4'b1111;
        wait_trigs(4, 600);
        check("t2_trig_count", trig_cyc_q.size(), 4);
        if (trig_cyc_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("t2_grant_order", trig_gid_q[i], i);
                check("t2_data_order", 32'(trig_data_q[i]), 32'hA0 + i);
                if (i > 0) check("t2_spacing", trig_cyc_q[i] - trig_cyc_q[i-1], 104);
            end
        end

        // Fairness: requester 2 always valid, requester 1 joins after its first grant.
        wait_quiet();
        clear_log();
        req_data[23:16] = 8'hB2;
        req_data[15:8]  = 8'hB1;
        req_valid[2]    = 1'b1;
        for (int i = 0; i < 500 && trig_cyc_q.size() < 3; i++) begin
            tick();
            req_valid[2] = 1'b1;
            if (trig_cyc_q.size() == 1 && rdy_cyc_q.size() == 1) req_valid[1] = 1'b1;
        end
        req_valid[2] = 1'b0;
        check("t3_trig_count", trig_cyc_q.size(), 3);
        if (trig_cyc_q.size() == 3) begin
            check("t3_grant0", trig_gid_q[0], 2);
            check("t3_grant1", trig_gid_q[1], 1);
            check("t3_grant2", trig_gid_q[2], 2);
        end

        // Request arriving during WAIT.
        wait_quiet();
        clear_log();
        req_data[7:0] = 8'h5A;
        req_valid[0]  = 1'b1;
        wait_trigs(1, 10);
        check("t4_first_trig", trig_cyc_q.size(), 1);
        t0 = (trig_cyc_q.size() > 0) ? trig_cyc_q[0] : cyc;
        while (cyc < t0 + 19) tick();
        req_data[31:24] = 8'hD3;
        req_valid[3]    = 1'b1;
        wait_trigs(2, 200);
        first3 = -1;
        foreach (rdy_cyc_q[i]) begin
            if (first3 < 0 && rdy_val_q[i][3]) first3 = rdy_cyc_q[i];
        end
        check("t4_ready3_offset", first3 - t0, 103);
        check("t4_trig_count", trig_cyc_q.size(), 2);
        if (trig_cyc_q.size() == 2) begin
            check("t4_trig_offset", trig_cyc_q[1] - t0, 104);
            check("t4_data", 32'(trig_data_q[1]), 32'hD3);
        end

        // Reset mid-frame.
        wait_quiet();
        clear_log();
        req_data[7:0] = 8'h11;
        req_valid[0]  = 1'b1;
        wait_trigs(1, 10);
        t0 = (trig_cyc_q.size() > 0) ? trig_cyc_q[0] : cyc;
        while (cyc < t0 + 39) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_trig", 32'(tx_trig), 32'd0);
        check("t5_tx_data", 32'(tx_data), 32'h00);
        check("t5_grant_id", 32'(grant_id), 32'd3);
        check("t5_ready", 32'(req_ready), 32'd0);
        check("t5_trig_count", trig_cyc_q.size(), 1);
        tick();
        req_data[7:0] = 8'h22;
        req_valid[0]  = 1'b1;
        #1;
        check("t5_regrant_ready", 32'(req_ready), 32'b0001);
        tick();
        check("t5_regrant_trig", 32'(tx_trig), 32'd1);
        check("t5_regrant_data", 32'(tx_data), 32'h22);

        // Withdrawal before IDLE.
        wait_quiet();
        clear_log();
        req_data[7:0]  = 8'h33;
        req_data[15:8] = 8'h44;
        req_valid[0]   = 1'b1;
        wait_trigs(1, 10);
        t0 = (trig_cyc_q.size() > 0) ? trig_cyc_q[0] : cyc;
        while (cyc < t0 + 29) tick();
        req_valid[1] = 1'b1;
        while (cyc < t0 + 59) tick();
        req_valid[1] = 1'b0;
        while (cyc < t0 + 150) tick();
        n_rdy1 = 0;
        foreach (rdy_val_q[i]) if (rdy_val_q[i][1]) n_rdy1++;
        check("t6_ready1_pulses", n_rdy1, 0);
        check("t6_trig_count", trig_cyc_q.size(), 1);
        check("t6_busy_cycles", busy_cnt, 103);
        check("t6_busy_after", 32'(busy), 32'd0);

        // Randomized traffic with withdrawals and occasional resets.
        do_reset(2);
        for (int c = 0; c < 3000; c++) begin
            tick();
            if ($urandom_range(999) == 0) begin
                reset     = 1'b1;
                req_valid = '0;
            end else begin
                reset = 1'b0;
                for (int i = 0; i < N; i++) begin
                    if (!req_valid[i] && $urandom_range(15) == 0) begin
                        req_data[8*i +: 8] = 8'($urandom);
                        req_valid[i]       = 1'b1;
                    end else if (req_valid[i] && $urandom_range(199) == 0) begin
                        req_valid[i] = 1'b0;
                    end
                end
            end
        end
        reset     = 1'b0;
        req_valid = '0;
        repeat (120) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler sharing the single `uart_tx` serializer among `N_REQ` byte producers (debug console, SDRAM test reporter, etc.). Accepts bytes on per-requester valid/ready handshakes and drives `tx_data` and a one-cycle `tx_trig` into `uart_tx`. `uart_tx` has no busy output, so the scheduler enforces frame spacing with an internal frame-time counter. Sits between the SoC status producers and `uart_tx`.

## Interface

Parameters:
- `N_REQ`, 4: number of requesters, 2..8.
- `CLK_FREQ`, 50_000_000: `sclk` frequency in Hz.
- `BAUD`, 9600: line rate; must match `uart_tx`.
- `GUARD`, 16: extra idle cycles appended after each frame.

Ports:
- `sclk` in 1: system clock; one clock; all logic on rising edge.
- `reset` in 1: reset is synchronous and active-high.
- `req_valid` in N_REQ: requester i has a byte pending.
- `req_data` in 8*N_REQ: byte of requester i at bits [8i+7:8i].
- `req_ready` out N_REQ: one-hot grant; byte i is transferred when `req_valid[i] & req_ready[i]`.
- `tx_data` out 8: byte to `uart_tx`.
- `tx_trig` out 1: one-cycle start pulse to `uart_tx`.
- `busy` out 1: high from grant until the frame window expires.
- `grant_id` out clog2(N_REQ): index of the last granted requester.

## Operation

- Constant `FRAME_CYCLES = (CLK_FREQ/BAUD)*10 + GUARD`, covering 1 start + 8 data + 1 stop bits plus guard. Integer division truncates. Counter width is `$clog2(FRAME_CYCLES+1)`.
- States:
  - **IDLE**: `req_ready` is the combinational one-hot of the round-robin winner among `req_valid`. The search starts at `grant_id+1` and wraps modulo `N_REQ`. If any request is valid: latch the winner's byte into `tx_data`, load `grant_id` with the winner, set `busy`, go to TRIG. With no valid requests, stay in IDLE and hold all `req_ready` low.
  - **TRIG**: `tx_trig`=1 for exactly this cycle. Load counter with `FRAME_CYCLES-1`. Go to WAIT.
  - **WAIT**: decrement the counter. At 0, clear `busy` and go to IDLE.
- `req_ready` is low in TRIG and WAIT.
- `tx_data` holds its value from the grant until the next grant, and stays stable for the whole frame.
- Requesters must hold `req_valid` and `req_data` until the handshake. Dropping `req_valid` before the handshake withdraws the request without error.
- Only one grant is made per frame. A requester that remains valid after being served has lowest priority in the next arbitration.

## Timing

- Reset values:
  - state = IDLE.
  - `tx_trig`=0, `tx_data`=8'h00, `busy`=0, `req_ready`=0.
  - `grant_id`=N_REQ-1, so requester 0 has first priority.
  - counter = 0.
- Latency: handshake at cycle T gives `tx_trig` at T+1 with the granted byte already on `tx_data`.
- Minimum spacing between `tx_trig` pulses is `FRAME_CYCLES+2` cycles: TRIG at T, WAIT from T+1 to T+FRAME_CYCLES, IDLE grant at T+FRAME_CYCLES+1, TRIG at T+FRAME_CYCLES+2.
- `busy` is high from T+1 (the TRIG cycle) through the last WAIT cycle.
- Simultaneous requests: exactly one grant per IDLE cycle; never two `req_ready` bits high at once.
- Reset asserted in any state:
  - Next cycle matches the reset values.
  - An in-flight frame is abandoned with no further `tx_trig`.
  - The reset of `uart_tx` is owned externally.
- Counter wrap cannot occur, because the counter is loaded only in TRIG.

## Structure

- Shared package `uart_pkg`:
  - State encoding `IDLE`/`TRIG`/`WAIT` (2-bit).
  - `FRAME_CYCLES` computation as a constant function of `CLK_FREQ`/`BAUD`/`GUARD`, reused by `uart_tx` and the future `uart_rx`.
- One sub-module `rr_arbiter`:
  - Parameter `N`.
  - Inputs: `req[N]`, `last[clog2 N]`.
  - Outputs: one-hot `gnt[N]`, index `gnt_id`, `any`.
  - Purely combinational, instantiated once.
- The top-level holds the FSM, data latch and frame counter.
- `uart_tx` is instantiated by the parent, not inside this block.

## Test plan

Bench uses `CLK_FREQ`=50_000_000, `BAUD`=5_000_000, `GUARD`=2, so `FRAME_CYCLES`=102.

- **Single request.** Reset for 10 cycles. Hold `req_valid`=4'b0001 with byte 8'hC3.
  - One `req_ready[0]` pulse; `tx_trig` on the next cycle with `tx_data`=8'hC3.
  - `busy` high for 103 cycles; no second trig.
- **All four requesters contend.** `req_valid`=4'b1111 with bytes 8'hA0..8'hA3, each held until its handshake.
  - Grants in order 0, 1, 2, 3.
  - `tx_data` sequence A0, A1, A2, A3.
  - Trig spacing exactly 104 cycles.
- **Fairness.** Requester 2 stays valid continuously; requester 1 asserts after requester 2's first grant.
  - Next grant goes to requester 1, then requester 2 again.
- **Request during WAIT.** Requester 3 asserts 20 cycles after a trig.
  - `req_ready[3]` stays low until IDLE at trig+103.
  - Its trig occurs at trig+104.
- **Reset mid-frame.** Assert `reset` 40 cycles into WAIT.
  - Next cycle: all outputs at reset values and `grant_id`=3.
  - With requester 0 valid after deassert: grant on the first IDLE cycle.
- **Withdrawal.** Requester 1 asserts valid during WAIT and drops it before IDLE.
  - No grant and no trig; `busy` stays 0 afterwards.
